// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing with redirect/stall priority, and the
// IF/ID pipeline register feeding decode.
module if_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              jtype,
    input  logic [DATA_W-1:0] jaddr,
    input  logic              excpt,
    input  logic [DATA_W-1:0] ejpc,
    input  logic [DATA_W-1:0] inst_in,
    output logic              rom_ce,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid,
    output logic [DATA_W-1:0] fetch_cnt
);

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [DATA_W-1:0] pc_p0;
    logic [DATA_W-1:0] pc_d;
    logic [DATA_W-1:0] id_pc_p1;
    logic [DATA_W-1:0] id_inst_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] id_pc_d;
    logic [DATA_W-1:0] id_inst_d;
    logic              vld_d;
    logic [DATA_W-1:0] fetch_cnt_q;
    logic [DATA_W-1:0] fetch_cnt_d;
    logic              redirect;

    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
        return {addr[DATA_W-1:2], 2'b00};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = OFF;
        endcase
    end

    assign redirect = excpt | jtype;

    always_comb begin
        pc_d = pc_p0;
        if (state_q == OFF) begin
            pc_d = '0;
        end else if (excpt) begin
            pc_d = word_align(ejpc);
        end else if (jtype) begin
            pc_d = word_align(jaddr);
        end else if (!stall) begin
            pc_d = pc_p0 + DATA_W'(4);
        end
    end

    // A redirect squashes the instruction fetched alongside it; no delay slot.
    always_comb begin
        id_pc_d     = id_pc_p1;
        id_inst_d   = id_inst_p1;
        vld_d       = vld_p1;
        fetch_cnt_d = fetch_cnt_q;
        if (state_q == OFF || redirect || flush) begin
            id_pc_d   = '0;
            id_inst_d = '0;
            vld_d     = 1'b0;
        end else if (!stall) begin
            id_pc_d     = pc_p0;
            id_inst_d   = inst_in;
            vld_d       = 1'b1;
            fetch_cnt_d = fetch_cnt_q + DATA_W'(1);
        end
    end

    // Stage p0: fetch address register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0 <= '0;
        end else begin
            pc_p0 <= pc_d;
        end
    end

    // Stage p1: IF/ID register and delivered-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_p1    <= '0;
            id_inst_p1  <= '0;
            vld_p1      <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            id_pc_p1    <= id_pc_d;
            id_inst_p1  <= id_inst_d;
            vld_p1      <= vld_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign rom_ce    = (state_q == RUN);
    assign pc        = pc_p0;
    assign id_pc     = id_pc_p1;
    assign id_inst   = id_inst_p1;
    assign id_valid  = vld_p1;
    assign fetch_cnt = fetch_cnt_q;

endmodule
